operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of register data.
REQ-002 SHALL have parameter NREG, default 32: number of architectural registers; x0 is hardwired zero.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port dec_valid, input, 1: decode offers an instruction.
REQ-006 SHALL have port dec_ready, output, 1: the block accepts the offered instruction this cycle.
REQ-007 SHALL have ports dec_rden1 and dec_rden2, input, 1 each: source operand enables.
REQ-008 SHALL have ports dec_raddr1 and dec_raddr2, input, 5 each: source register indices.
REQ-009 SHALL have ports dec_wren, input, 1, and dec_waddr, input, 5: the instruction writes a destination register.
REQ-010 SHALL have port ex_valid, output, 1: an operand bundle is held for execute.
REQ-011 SHALL have port ex_ready, input, 1: execute consumes the held bundle.
REQ-012 SHALL have ports ex_rdata1 and ex_rdata2, output, XLEN each: operand values.
REQ-013 SHALL have ports ex_wren, output, 1, and ex_waddr, output, 5: forwarded destination information.
REQ-014 SHALL have ports wb_valid, input, 1, wb_waddr, input, 5, and wb_wdata, input, XLEN: result retiring this cycle.
REQ-015 SHALL have port flush, input, 1: kill the held bundle.
REQ-016 SHALL have port register_rin, output, register_rin_type: register-file read request.
REQ-017 SHALL have port register_out, input, register_out_type: register-file read data, combinational in the same cycle.
REQ-018 SHALL have port register_win, output, register_win_type: register-file write request.
REQ-019 SHALL have port stall_cnt, output, 32: count of hazard-stall cycles.

Function
REQ-020 SHALL drive register_rin combinationally from the dec_rden*/dec_raddr* inputs.
REQ-021 SHALL drive register_win combinationally: wren=wb_valid, waddr=wb_waddr, wdata=wb_wdata.
REQ-022 SHALL keep a busy bitmap of NREG bits in which bit 0 is always 0.
REQ-023 SHALL treat a source as hazarded when rden=1, raddr!=0, busy[raddr]=1, and the register is not being bypassed (not wb_valid with wb_waddr==raddr).
REQ-024 SHALL treat the instruction as a WAW hazard when dec_wren=1, dec_waddr!=0 and busy[dec_waddr]=1, with no bypass exemption.
REQ-025 SHALL compute dec_ready = (!ex_valid || ex_ready) && !hazard && !flush.
REQ-026 SHALL issue when dec_valid && dec_ready, capturing the operands and destination into the output register; ex_valid rises the next cycle, giving latency 1.
REQ-027 SHALL select operand data by priority: rden=0 or raddr=0 gives 0; a wb bypass match gives wb_wdata; otherwise register_out.rdataN.
REQ-028 SHALL, on issue with dec_wren=1 and dec_waddr!=0, set busy[dec_waddr].
REQ-029 SHALL, on wb_valid, clear busy[wb_waddr]; when set and clear hit the same index in one cycle, set wins.
REQ-030 SHALL hold the bundle stable while ex_valid && !ex_ready.
REQ-031 SHALL, when ex_ready && ex_valid with no issue, clear ex_valid next cycle.
REQ-032 SHALL, on flush, clear ex_valid next cycle, clear busy[ex_waddr] if the killed bundle had ex_wren=1, and block any issue that cycle.
REQ-033 SHALL increment stall_cnt by 1 each cycle in which dec_valid=1 and hazard=1, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-034 SHALL, when rst=1 at a clock edge, clear ex_valid, the busy bitmap and stall_cnt.
REQ-035 SHALL, on that edge, set ex_rdata1, ex_rdata2, ex_waddr and ex_wren to 0.
REQ-036 SHALL take reset priority over issue, flush and writeback in the same cycle.
REQ-037 SHALL keep dec_ready at 0 while rst=1.

Structure
REQ-038 SHALL add an issue bundle type and a writeback type to package wires, alongside the register-file types.
REQ-039 SHALL place the busy bitmap with its set/clear/query logic in sub-module scoreboard.

Verification
REQ-040 SHALL cover back-to-back independence: issue addi x1 then addi x2 with ex_ready=1 and no hazard -> ex_valid on consecutive cycles, stall_cnt=0.
REQ-041 SHALL cover RAW stall: issue wr x5, then rs1=x5 with no writeback for 3 cycles -> dec_ready=0 for 3 cycles, stall_cnt=3.
REQ-042 SHALL cover RAW bypass: wb_valid with x5=0xDEADBEEF in the stall cycle -> issue that cycle with ex_rdata1=0xDEADBEEF.
REQ-043 SHALL cover x0: rs1=x0 and rd=x0 with x0 marked written -> no stall, ex_rdata1=0, busy unchanged.
REQ-044 SHALL cover backpressure plus flush: ex_ready=0 for 4 cycles -> bundle stable; then flush -> ex_valid=0 and busy[rd] cleared.
REQ-045 SHALL cover reset mid-operation: rst with busy={x3,x7} and ex_valid=1 -> all cleared next cycle, and a following read of x3 issues without stall.

Source files
------------

// File: rtl/wires_pkg.sv
// Shared payload types for operand fetch: register-file ports, issue bundle and writeback.
package wires;
    localparam int unsigned XLEN_W = 32;
    localparam int unsigned AW     = 5;

    typedef struct packed {
        logic          rden1;
        logic [AW-1:0] raddr1;
        logic          rden2;
        logic [AW-1:0] raddr2;
    } register_rin_type;

    typedef struct packed {
        logic [XLEN_W-1:0] rdata1;
        logic [XLEN_W-1:0] rdata2;
    } register_out_type;

    typedef struct packed {
        logic              wren;
        logic [AW-1:0]     waddr;
        logic [XLEN_W-1:0] wdata;
    } register_win_type;

    typedef struct packed {
        logic              wren;
        logic [AW-1:0]     waddr;
        logic [XLEN_W-1:0] rdata1;
        logic [XLEN_W-1:0] rdata2;
    } issue_bundle_type;

    typedef struct packed {
        logic              valid;
        logic [AW-1:0]     waddr;
        logic [XLEN_W-1:0] wdata;
    } writeback_type;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-register bitmap: set on issue, cleared by writeback or flush, queried for RAW/WAW hazards.
module scoreboard
    import wires::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_idx,
    input  logic          i_fl_en,
    input  logic [AW-1:0] i_fl_idx,
    input  logic          i_rden1,
    input  logic [AW-1:0] i_raddr1,
    input  logic          i_rden2,
    input  logic [AW-1:0] i_raddr2,
    input  logic          i_wren,
    input  logic [AW-1:0] i_waddr,
    output logic          o_hazard_c
);
    localparam int unsigned NSLOT = 1 << AW;
    // x0 and any slot beyond NREG can never be marked busy
    localparam logic [NSLOT-1:0] LIVE = NSLOT'((64'(1) << NREG) - 64'(1)) & ~NSLOT'(1);

    logic [NSLOT-1:0] r_busy;
    logic [NSLOT-1:0] w_busy_nxt;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_waw;

    // Clears first so a same-index set in the same cycle wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wb_en) w_busy_nxt[i_wb_idx] = 1'b0;
        if (i_fl_en) w_busy_nxt[i_fl_idx] = 1'b0;
        if (i_set_en) w_busy_nxt[i_set_idx] = 1'b1;
        w_busy_nxt = w_busy_nxt & LIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    always_comb begin
        w_haz1 = i_rden1 && (i_raddr1 != '0) && r_busy[i_raddr1]
                 && !(i_wb_en && (i_wb_idx == i_raddr1));
        w_haz2 = i_rden2 && (i_raddr2 != '0) && r_busy[i_raddr2]
                 && !(i_wb_en && (i_wb_idx == i_raddr2));
        w_waw  = i_wren && (i_waddr != '0) && r_busy[i_waddr];
        o_hazard_c = w_haz1 || w_haz2 || w_waw;
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources with writeback bypass, stalls on hazards, holds one bundle for execute.
module operand_fetch
    import wires::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic                    dec_rden1,
    input  logic                    dec_rden2,
    input  logic [4:0]              dec_raddr1,
    input  logic [4:0]              dec_raddr2,
    input  logic                    dec_wren,
    input  logic [4:0]              dec_waddr,
    output logic                    ex_valid,
    input  logic                    ex_ready,
    output logic [XLEN-1:0]         ex_rdata1,
    output logic [XLEN-1:0]         ex_rdata2,
    output logic                    ex_wren,
    output logic [4:0]              ex_waddr,
    input  logic                    wb_valid,
    input  logic [4:0]              wb_waddr,
    input  logic [XLEN-1:0]         wb_wdata,
    input  logic                    flush,
    output register_rin_type        register_rin,
    input  register_out_type        register_out,
    output register_win_type        register_win,
    output logic [31:0]             stall_cnt
);
    logic             r_ex_valid;
    issue_bundle_type r_bundle;
    logic [31:0]      r_stall_cnt;

    writeback_type    w_wb;
    issue_bundle_type w_bundle_nxt;
    logic             w_hazard;
    logic             w_issue;

    assign w_wb = '{valid: wb_valid, waddr: wb_waddr, wdata: XLEN_W'(wb_wdata)};

    assign register_rin = '{rden1: dec_rden1, raddr1: dec_raddr1,
                            rden2: dec_rden2, raddr2: dec_raddr2};
    assign register_win = '{wren: w_wb.valid, waddr: w_wb.waddr, wdata: w_wb.wdata};

    scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_issue && dec_wren),
        .i_set_idx  (dec_waddr),
        .i_wb_en    (w_wb.valid),
        .i_wb_idx   (w_wb.waddr),
        .i_fl_en    (flush && r_ex_valid && r_bundle.wren),
        .i_fl_idx   (r_bundle.waddr),
        .i_rden1    (dec_rden1),
        .i_raddr1   (dec_raddr1),
        .i_rden2    (dec_rden2),
        .i_raddr2   (dec_raddr2),
        .i_wren     (dec_wren),
        .i_waddr    (dec_waddr),
        .o_hazard_c (w_hazard)
    );

    assign dec_ready = !rst && (!r_ex_valid || ex_ready) && !w_hazard && !flush;
    assign w_issue   = dec_valid && dec_ready;

    // Operand priority: disabled/x0 -> 0, retiring writeback -> bypass, else register file
    always_comb begin
        w_bundle_nxt.wren  = dec_wren;
        w_bundle_nxt.waddr = dec_waddr;
        if (!dec_rden1 || dec_raddr1 == '0)                 w_bundle_nxt.rdata1 = '0;
        else if (w_wb.valid && w_wb.waddr == dec_raddr1)    w_bundle_nxt.rdata1 = w_wb.wdata;
        else                                                w_bundle_nxt.rdata1 = register_out.rdata1;
        if (!dec_rden2 || dec_raddr2 == '0)                 w_bundle_nxt.rdata2 = '0;
        else if (w_wb.valid && w_wb.waddr == dec_raddr2)    w_bundle_nxt.rdata2 = w_wb.wdata;
        else                                                w_bundle_nxt.rdata2 = register_out.rdata2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_bundle   <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_bundle   <= w_bundle_nxt;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                        r_stall_cnt <= '0;
        else if (dec_valid && w_hazard) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign ex_valid  = r_ex_valid;
    assign ex_rdata1 = XLEN'(r_bundle.rdata1);
    assign ex_rdata2 = XLEN'(r_bundle.rdata2);
    assign ex_wren   = r_bundle.wren;
    assign ex_waddr  = r_bundle.waddr;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a register-file environment, a pending-write model and literal pins.
module tb_operand_fetch;
    import wires::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid, dec_ready;
    logic             dec_rden1, dec_rden2;
    logic [4:0]       dec_raddr1, dec_raddr2;
    logic             dec_wren;
    logic [4:0]       dec_waddr;
    logic             ex_valid, ex_ready;
    logic [31:0]      ex_rdata1, ex_rdata2;
    logic             ex_wren;
    logic [4:0]       ex_waddr;
    logic             wb_valid;
    logic [4:0]       wb_waddr;
    logic [31:0]      wb_wdata;
    logic             flush;
    register_rin_type register_rin;
    register_out_type register_out;
    register_win_type register_win;
    logic [31:0]      stall_cnt;

    logic [31:0] env_regs [32];
    assign register_out = '{rdata1: env_regs[register_rin.raddr1],
                            rdata2: env_regs[register_rin.raddr2]};

    operand_fetch #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rden1(dec_rden1), .dec_rden2(dec_rden2),
        .dec_raddr1(dec_raddr1), .dec_raddr2(dec_raddr2),
        .dec_wren(dec_wren), .dec_waddr(dec_waddr),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_wren(ex_wren), .ex_waddr(ex_waddr),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .flush(flush),
        .register_rin(register_rin), .register_out(register_out),
        .register_win(register_win), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: which registers have an outstanding write, what execute holds, and register contents
    bit          m_pending [32];
    logic [31:0] m_regs [32];
    bit          m_ex_valid;
    logic [31:0] m_rd1, m_rd2;
    bit          m_wren;
    logic [4:0]  m_waddr;
    logic [31:0] m_stall;
    bit          m_known = 1'b0;
    logic        last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit waits_on(input logic en, input logic [4:0] ra);
        return en && ra != 5'd0 && m_pending[ra] && !(wb_valid && wb_waddr == ra);
    endfunction

    function automatic logic [31:0] operand(input logic en, input logic [4:0] ra);
        if (!en || ra == 5'd0) return 32'd0;
        if (wb_valid && wb_waddr == ra) return wb_wdata;
        return m_regs[ra];
    endfunction

    // One clock: check combinational outputs, advance model at the edge, check registered outputs
    task automatic tick();
        bit          haz, exp_ready, iss;
        logic [31:0] o1, o2;
        haz = waits_on(dec_rden1, dec_raddr1) || waits_on(dec_rden2, dec_raddr2)
              || (dec_wren && dec_waddr != 5'd0 && m_pending[dec_waddr]);
        exp_ready = !rst && (!m_ex_valid || ex_ready) && !haz && !flush;
        o1 = operand(dec_rden1, dec_raddr1);
        o2 = operand(dec_rden2, dec_raddr2);
        iss = dec_valid && exp_ready;
        #1;
        last_ready = dec_ready;
        chk("dec_ready", 32'(dec_ready), 32'(exp_ready));
        chk("reg_rin", 32'(register_rin), 32'({dec_rden1, dec_raddr1, dec_rden2, dec_raddr2}));
        chk("reg_win_ctl", 32'({register_win.wren, register_win.waddr}), 32'({wb_valid, wb_waddr}));
        if (wb_valid) chk("reg_win_data", register_win.wdata, wb_wdata);
        @(posedge clk);
        if (rst) begin
            m_stall = 32'd0;
            for (int i = 0; i < 32; i++) m_pending[i] = 1'b0;
            m_ex_valid = 1'b0; m_rd1 = 32'd0; m_rd2 = 32'd0; m_wren = 1'b0; m_waddr = 5'd0;
            m_known = 1'b1;
        end else begin
            if (dec_valid && haz) m_stall = m_stall + 32'd1;
            if (wb_valid) m_pending[wb_waddr] = 1'b0;
            if (flush && m_ex_valid && m_wren) m_pending[m_waddr] = 1'b0;
            if (iss && dec_wren && dec_waddr != 5'd0) m_pending[dec_waddr] = 1'b1;
            if (flush) m_ex_valid = 1'b0;
            else if (iss) begin
                m_ex_valid = 1'b1; m_rd1 = o1; m_rd2 = o2; m_wren = dec_wren; m_waddr = dec_waddr;
            end else if (ex_ready) m_ex_valid = 1'b0;
        end
        if (wb_valid) m_regs[wb_waddr] = wb_wdata;
        #1;
        if (register_win.wren) env_regs[register_win.waddr] = register_win.wdata;
        if (m_known) begin
            chk("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
            chk("ex_rdata1", ex_rdata1, m_rd1);
            chk("ex_rdata2", ex_rdata2, m_rd2);
            chk("ex_dest", 32'({ex_wren, ex_waddr}), 32'({m_wren, m_waddr}));
            chk("stall_cnt", stall_cnt, m_stall);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_rden1 = 1'b0; dec_raddr1 = 5'd0; dec_rden2 = 1'b0; dec_raddr2 = 5'd0;
        dec_wren = 1'b0; dec_waddr = 5'd0; wb_valid = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
        flush = 1'b0;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        idle();
        dec_valid = 1'b1;
        dec_rden1 = 1'b1; dec_raddr1 = rs1;
        dec_rden2 = 1'b1; dec_raddr2 = rs2;
        dec_wren = 1'b1; dec_waddr = rd;
    endtask

    task automatic retire(input logic [4:0] rd, input logic [31:0] val);
        wb_valid = 1'b1; wb_waddr = rd; wb_wdata = val;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            env_regs[i] = 32'hA000_0000 | 32'(i);
            m_regs[i]   = 32'hA000_0000 | 32'(i);
            m_pending[i] = 1'b0;
        end
        m_ex_valid = 1'b0; m_rd1 = 32'd0; m_rd2 = 32'd0; m_wren = 1'b0; m_waddr = 5'd0; m_stall = 32'd0;
        idle();
        rst = 1'b1; ex_ready = 1'b1;
        tick(); tick();
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_stall", stall_cnt, 32'd0);
        rst = 1'b0;

        // Independent back-to-back issues
        offer(5'd0, 5'd0, 5'd1); tick();
        chk("b2b_first_valid", 32'(ex_valid), 32'd1);
        chk("b2b_first_rd", 32'(ex_waddr), 32'd1);
        offer(5'd0, 5'd0, 5'd2); tick();
        chk("b2b_second_ready", 32'(last_ready), 32'd1);
        chk("b2b_second_rd", 32'(ex_waddr), 32'd2);
        chk("b2b_stall", stall_cnt, 32'd0);
        idle(); retire(5'd1, 32'h11); tick();
        idle(); retire(5'd2, 32'h22); tick();

        // RAW stall on x5 for three cycles, then bypass from writeback
        offer(5'd1, 5'd0, 5'd5); tick();
        chk("raw_src_x1", ex_rdata1, 32'h11);
        for (int i = 0; i < 3; i++) begin
            offer(5'd5, 5'd0, 5'd6); tick();
            chk("raw_stalled", 32'(last_ready), 32'd0);
        end
        chk("raw_stall_cnt", stall_cnt, 32'd3);
        offer(5'd5, 5'd0, 5'd6); retire(5'd5, 32'hDEADBEEF); tick();
        chk("bypass_ready", 32'(last_ready), 32'd1);
        chk("bypass_data", ex_rdata1, 32'hDEADBEEF);
        chk("bypass_stall_cnt", stall_cnt, 32'd3);
        idle(); retire(5'd6, 32'h66); tick();

        // x0 as destination never becomes busy and always reads zero
        offer(5'd0, 5'd0, 5'd0); tick();
        offer(5'd0, 5'd0, 5'd0); tick();
        chk("x0_ready", 32'(last_ready), 32'd1);
        chk("x0_data", ex_rdata1, 32'd0);

        // Set and clear of the same register in one cycle: set wins
        offer(5'd0, 5'd0, 5'd4); retire(5'd4, 32'h44); tick();
        offer(5'd4, 5'd0, 5'd8); tick();
        chk("setwins_stall", 32'(last_ready), 32'd0);
        offer(5'd4, 5'd0, 5'd8); retire(5'd4, 32'h45); tick();
        chk("setwins_bypass", ex_rdata1, 32'h45);
        idle(); retire(5'd8, 32'h88); tick();

        // Backpressure holds the bundle, then flush kills it and frees x7
        ex_ready = 1'b0;
        offer(5'd1, 5'd2, 5'd7); tick();
        for (int i = 0; i < 4; i++) begin
            offer(5'd2, 5'd0, 5'd9); tick();
            chk("bp_blocked", 32'(last_ready), 32'd0);
            chk("bp_stable", {ex_rdata1[15:0], ex_rdata2[15:0]}, 32'h0011_0022);
        end
        chk("bp_no_stall", stall_cnt, 32'd4);
        idle(); flush = 1'b1; tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        ex_ready = 1'b1;
        offer(5'd7, 5'd0, 5'd10); tick();
        chk("flush_freed_x7", 32'(last_ready), 32'd1);
        idle(); retire(5'd10, 32'hAA); tick();

        // Reset with x3/x7 pending and a held bundle
        offer(5'd0, 5'd0, 5'd3); tick();
        offer(5'd0, 5'd0, 5'd7); tick();
        ex_ready = 1'b0;
        offer(5'd3, 5'd0, 5'd12); tick();
        rst = 1'b1; offer(5'd3, 5'd0, 5'd12); tick();
        rst = 1'b0;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        ex_ready = 1'b1;
        offer(5'd3, 5'd0, 5'd11); tick();
        chk("rst_x3_ready", 32'(last_ready), 32'd1);
        chk("rst_x3_data", ex_rdata1, 32'hA000_0003);
        idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
